imm_gen_stage: RTL and testbench

//  Registered, parametrised successor to the combinational immediate generator.

---
 rtl/imm_gen_stage.sv | 181 ++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between decode and execute. It extracts and
// sign-extends the immediate and carries the PC, behind a 2-entry skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_type,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    typedef enum logic [2:0] {
        TYPE_R   = 3'b000,
        TYPE_I   = 3'b001,
        TYPE_S   = 3'b010,
        TYPE_B   = 3'b011,
        TYPE_U   = 3'b100,
        TYPE_J   = 3'b101,
        TYPE_Z   = 3'b110,
        TYPE_RSV = 3'b111
    } imm_type_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_e;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    logic            sign;
    logic [XLEN-1:0] new_imm;
    logic            new_illegal;

    always_comb begin
        sign        = in_instr[31];
        new_imm     = '0;
        new_illegal = 1'b0;
        case (imm_type_e'(in_type))
            TYPE_R: new_imm = '0;
            TYPE_I: begin
                new_imm       = {XLEN{sign}};
                new_imm[11:0] = in_instr[31:20];
            end
            TYPE_S: begin
                new_imm       = {XLEN{sign}};
                new_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
            end
            TYPE_B: begin
                new_imm       = {XLEN{sign}};
                new_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0};
            end
            TYPE_U: begin
                // Upper word only exists for XLEN=64 and is filled from the sign bit.
                new_imm       = {XLEN{sign}};
                new_imm[31:0] = {in_instr[31:12], 12'b0};
            end
            TYPE_J: begin
                new_imm       = {XLEN{sign}};
                new_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0};
            end
            TYPE_Z: begin
                new_imm      = '0;
                new_imm[4:0] = in_instr[19:15];
            end
            default: begin
                new_imm     = '0;
                new_illegal = 1'b1;
            end
        endcase
    end

    occ_e            state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic            main_ill_q, main_ill_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            skid_ill_q, skid_ill_d;
    logic            accept;
    logic            emit;

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = in_ready_q;
    assign out_imm     = main_imm_q;
    assign out_pc      = main_pc_q;
    assign out_illegal = main_ill_q;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_pc_d  = main_pc_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_pc_d  = skid_pc_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        main_imm_d = new_imm;
                        main_pc_d  = in_pc;
                        main_ill_d = new_illegal;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state_d    = TWO;
                        skid_imm_d = new_imm;
                        skid_pc_d  = in_pc;
                        skid_ill_d = new_illegal;
                    end else if (accept && emit) begin
                        main_imm_d = new_imm;
                        main_pc_d  = in_pc;
                        main_ill_d = new_illegal;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d    = ONE;
                        main_imm_d = skid_imm_q;
                        main_pc_d  = skid_pc_q;
                        main_ill_d = skid_ill_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready derived from next occupancy, never from out_ready directly.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_imm_q <= '0;
            main_pc_q  <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_pc_q  <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_imm_q <= main_imm_d;
            main_pc_q  <= main_pc_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_pc_q  <= skid_pc_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance,
// directed type/backpressure/flush/reset cases plus random handshake traffic.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [2:0]  in_type;
    logic [31:0] in_pc, out_imm, out_pc;

    logic        w_flush;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
    logic [31:0] w_in_instr;
    logic [2:0]  w_in_type;
    logic [63:0] w_in_pc, w_out_imm, w_out_pc;

    imm_gen_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_type(in_type), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .in_type(w_in_type), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
        .out_illegal(w_out_illegal), .out_pc(w_out_pc)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    exp_t        hold32, hold64;
    logic        stall32, stall64;
    int unsigned acc32, acc64;
    int unsigned n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: signed field concatenation, widened by assignment.
    function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] t);
        logic signed [63:0] v;
        case (t)
            3'd1: v = $signed(ins[31:20]);
            3'd2: v = $signed({ins[31:25], ins[11:7]});
            3'd3: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3'd4: v = $signed({ins[31:12], 12'h000});
            3'd5: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            3'd6: v = {59'd0, ins[19:15]};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic mon32();
        exp_t        e;
        logic [63:0] m;
        if (rst || flush) begin
            q32.delete();
            stall32 = 1'b0;
            return;
        end
        if (stall32) begin
            check("hold_imm32", 64'(out_imm), hold32.imm);
            check("hold_pc32", 64'(out_pc), hold32.pc);
            check("hold_ill32", 64'(out_illegal), 64'(hold32.ill));
        end
        if (out_valid && out_ready) begin
            if (q32.size() == 0) begin
                check("spurious32", 64'(out_valid), 64'd0);
            end else begin
                e = q32.pop_front();
                check("imm32", 64'(out_imm), e.imm);
                check("ill32", 64'(out_illegal), 64'(e.ill));
                check("pc32", 64'(out_pc), e.pc);
            end
        end
        if (in_valid && in_ready) begin
            m     = model_imm(in_instr, in_type);
            e.imm = {32'd0, m[31:0]};
            e.ill = (in_type == 3'd7);
            e.pc  = {32'd0, in_pc};
            q32.push_back(e);
            acc32++;
        end
        stall32    = out_valid && !out_ready;
        hold32.imm = 64'(out_imm);
        hold32.pc  = 64'(out_pc);
        hold32.ill = out_illegal;
    endtask

    task automatic mon64();
        exp_t e;
        if (rst || w_flush) begin
            q64.delete();
            stall64 = 1'b0;
            return;
        end
        if (stall64) begin
            check("hold_imm64", w_out_imm, hold64.imm);
            check("hold_pc64", w_out_pc, hold64.pc);
            check("hold_ill64", 64'(w_out_illegal), 64'(hold64.ill));
        end
        if (w_out_valid && w_out_ready) begin
            if (q64.size() == 0) begin
                check("spurious64", 64'(w_out_valid), 64'd0);
            end else begin
                e = q64.pop_front();
                check("imm64", w_out_imm, e.imm);
                check("ill64", 64'(w_out_illegal), 64'(e.ill));
                check("pc64", w_out_pc, e.pc);
            end
        end
        if (w_in_valid && w_in_ready) begin
            e.imm = model_imm(w_in_instr, w_in_type);
            e.ill = (w_in_type == 3'd7);
            e.pc  = w_in_pc;
            q64.push_back(e);
            acc64++;
        end
        stall64    = w_out_valid && !w_out_ready;
        hold64.imm = w_out_imm;
        hold64.pc  = w_out_pc;
        hold64.ill = w_out_illegal;
    endtask

    // Monitors sample mid-cycle; stimulus changes 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        mon32();
        mon64();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] ins, input logic [2:0] t, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_type  = t;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
        check("latency32", 64'(out_valid), 64'd1);
    endtask

    task automatic send64(input logic [31:0] ins, input logic [2:0] t, input logic [63:0] pc);
        w_in_valid = 1'b1;
        w_in_instr = ins;
        w_in_type  = t;
        w_in_pc    = pc;
        step();
        w_in_valid = 1'b0;
        check("latency64", 64'(w_out_valid), 64'd1);
    endtask

    int unsigned cyc;

    initial begin
        n_tests = 0; n_fail = 0; acc32 = 0; acc64 = 0;
        stall32 = 1'b0; stall64 = 1'b0;
        hold32 = '0; hold64 = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_type = '0; in_pc = '0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
        w_in_instr = '0; w_in_type = '0; w_in_pc = '0;
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_ill", 64'(out_illegal), 64'd0);
        check("rst_out_valid64", 64'(w_out_valid), 64'd0);
        rst = 1'b0;
        step();

        send32(32'hFFF00093, 3'd1, 32'h0000_0100);
        check("type_I", 64'(out_imm), 64'h0000_0000_FFFF_FFFF);
        send32(32'hFE000EE3, 3'd3, 32'h0000_0104);
        check("type_B", 64'(out_imm), 64'h0000_0000_FFFF_FFFC);
        send32(32'h123450B7, 3'd4, 32'h0000_0108);
        check("type_U", 64'(out_imm), 64'h0000_0000_1234_5000);
        send32(32'h008000EF, 3'd5, 32'h0000_010C);
        check("type_J", 64'(out_imm), 64'h0000_0000_0000_0008);
        send32(32'h000F8073, 3'd6, 32'h0000_0110);
        check("type_Z", 64'(out_imm), 64'h0000_0000_0000_001F);
        send32(32'hFE112E23, 3'd2, 32'h0000_0114);
        check("type_S", 64'(out_imm), 64'h0000_0000_FFFF_FFFC);
        send32(32'hFFFFFFB3, 3'd0, 32'h0000_0118);
        check("type_R", 64'(out_imm), 64'd0);

        send32(32'hDEADBEEF, 3'd7, 32'h0000_2000);
        check("illegal_flag", 64'(out_illegal), 64'd1);
        check("illegal_imm", 64'(out_imm), 64'd0);
        check("illegal_pc", 64'(out_pc), 64'h0000_0000_0000_2000);
        send32(32'h00500093, 3'd1, 32'h0000_2004);
        check("legal_after_ill", 64'(out_illegal), 64'd0);
        check("legal_after_ill_imm", 64'(out_imm), 64'd5);
        step();

        out_ready = 1'b0;
        send32(32'h00100093, 3'd1, 32'h0000_3000);
        check("bp_ready_A", 64'(in_ready), 64'd1);
        send32(32'h00200093, 3'd1, 32'h0000_3004);
        check("bp_ready_B", 64'(in_ready), 64'd0);
        check("bp_head", 64'(out_imm), 64'd1);
        step();
        step();
        out_ready = 1'b1;
        step();
        check("bp_second", 64'(out_imm), 64'd2);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_ready_back", 64'(in_ready), 64'd1);

        out_ready = 1'b0;
        send32(32'h00300093, 3'd1, 32'h0000_4000);
        send32(32'h00400093, 3'd1, 32'h0000_4004);
        in_valid = 1'b1; in_instr = 32'h00900093; in_type = 3'd1; in_pc = 32'h0000_4008;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", 64'(out_valid), 64'd0);
        check("flush2_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        out_ready = 1'b0;
        send32(32'h00600093, 3'd1, 32'h0000_5000);
        in_valid = 1'b1; in_instr = 32'h00A00093; in_type = 3'd1; in_pc = 32'h0000_5004;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_out_valid", 64'(out_valid), 64'd0);
        check("flush1_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        out_ready = 1'b0;
        send32(32'h00700093, 3'd1, 32'h0000_6000);
        send32(32'h00800093, 3'd1, 32'h0000_6004);
        #2 rst = 1'b1;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        check("rstmid_imm", 64'(out_imm), 64'd0);
        check("rstmid_pc", 64'(out_pc), 64'd0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rstmid_no_output", 64'(out_valid), 64'd0);

        acc32 = 0; cyc = 0;
        while (acc32 < 2000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = $urandom;
            in_type   = 3'($urandom_range(0, 7));
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            step();
            cyc++;
        end
        check("rand32_budget", 64'(acc32 >= 2000), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("drain32", 64'(q32.size()), 64'd0);

        send64(32'h800000B7, 3'd4, 64'hFFFF_0000_0000_1000);
        check("u64", w_out_imm, 64'hFFFF_FFFF_8000_0000);
        check("u64_pc", w_out_pc, 64'hFFFF_0000_0000_1000);
        send64(32'h7FF00093, 3'd1, 64'h0000_0000_0000_1004);
        check("i64", w_out_imm, 64'h0000_0000_0000_07FF);
        step();

        acc64 = 0; cyc = 0;
        while (acc64 < 10000 && cyc < 60000) begin
            w_in_valid  = ($urandom_range(0, 9) < 7);
            w_in_instr  = $urandom;
            w_in_type   = 3'($urandom_range(0, 7));
            w_in_pc     = {$urandom, $urandom};
            w_out_ready = ($urandom_range(0, 9) < 6);
            w_flush     = ($urandom_range(0, 499) == 0);
            step();
            cyc++;
        end
        w_flush = 1'b0;
        check("rand64_budget", 64'(acc64 >= 10000), 64'd1);
        w_in_valid = 1'b0; w_out_ready = 1'b1;
        repeat (4) step();
        check("drain64", 64'(q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
